// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bits needed to hold the values 0 .. value-1 (minimum 1 bit).
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: diff = x - y - bi, bo = borrow out.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial D = A - B - Bin, LSB first; SERIAL_SUB_OVF_EN adds signed-overflow output ovf.
// Latency: done pulses WIDTH+1 cycles after start is driven; one result per WIDTH+1 cycles.
// Backpressure: start is ignored while busy; start in DONE chains the next operation directly.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             shift_en;
    logic             last;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             diff;
    logic             nbr;

    full_subtractor u_fs (
        .x    (sa[0]),
        .y    (sb[0]),
        .bi   (br),
        .diff (diff),
        .bo   (nbr)
    );

    assign last = (cnt == '0);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake outputs; DONE accepts start like IDLE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture and one subtractor step per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            res <= '0;
            br  <= 1'b0;
            cnt <= '0;
        end else if (load) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            res <= '0;
            cnt <= CW'(WIDTH - 1);
        end else if (shift_en) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= {diff, res[WIDTH-1:1]};
            br  <= nbr;
            if (!last) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Visible result changes only on entry to DONE, never mid-operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d    <= '0;
            bout <= 1'b0;
        end else if (shift_en && last) begin
            d    <= {diff, res[WIDTH-1:1]};
            bout <= nbr;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    // Operand MSBs are kept aside because sa/sb are consumed by shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (load) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (shift_en && last) begin
                ovf <= (a_msb ^ b_msb) & (a_msb ^ diff);
            end
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
    } exp_t;

    exp_t         sb_q[$];
    int           compared   = 0;
    int           mismatched = 0;
    logic [W-1:0] held_d;
    logic         held_bout;
    logic         held_ovf;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one request and push its reference result.
    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        exp_t e;
        int   diffv;
        diffv  = int'(av) - int'(bv) - int'(bi);
        e.d    = diffv[W-1:0];
        e.bout = (diffv < 0);
        e.ovf  = (av[W-1] ^ bv[W-1]) & (av[W-1] ^ e.d[W-1]);
        sb_q.push_back(e);
        a     = av;
        b     = bv;
        bin   = bi;
        start = 1'b1;
    endtask

    // Follow one operation from the drive cycle to its done pulse.
    task automatic wait_result(input string tag, input bit keep_start, input bit disturb);
        int   busy_n;
        bit   seen;
        exp_t e;
        busy_n = 0;
        seen   = 1'b0;
        for (int i = 1; i <= 3 * W + 4 && !seen; i++) begin
            @(negedge clk);
            if (i == 1 && !keep_start) start = 1'b0;
            if (disturb && i == 2) begin
                a     = W'($urandom);
                b     = W'($urandom);
                bin   = 1'($urandom);
                start = 1'b1;
            end
            if (disturb && i == 3) start = 1'b0;
            if (busy) begin
                busy_n++;
                check({tag, "_d_held_while_busy"}, 32'(d), 32'(held_d));
            end
            if (done) begin
                seen = 1'b1;
                check({tag, "_latency"}, i, W + 1);
                check({tag, "_busy_cycles"}, busy_n, W);
                if (sb_q.size() == 0) begin
                    check({tag, "_unexpected_done"}, 32'(done), 0);
                end else begin
                    e = sb_q.pop_front();
                    check({tag, "_d"}, 32'(d), 32'(e.d));
                    check({tag, "_bout"}, 32'(bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
                    check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
                    held_d    = e.d;
                    held_bout = e.bout;
                    held_ovf  = e.ovf;
                end
            end
        end
        if (!seen) check({tag, "_done_timeout"}, 32'(done), 1);
    endtask

    // Cycle after a done with no new start: pulse over, result held.
    task automatic finish_idle(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse_len"}, 32'(done), 0);
        check({tag, "_d_hold"}, 32'(d), 32'(held_d));
        check({tag, "_bout_hold"}, 32'(bout), 32'(held_bout));
    endtask

    initial begin
        bit done_seen;
        rst       = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        held_d    = '0;
        held_bout = 1'b0;
        held_ovf  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_d", 32'(d), 0);
        check("reset_bout", 32'(bout), 0);
        rst = 1'b0;
        @(negedge clk);

        launch(4'd9, 4'd3, 1'b0);
        wait_result("sub_9_3", 1'b0, 1'b0);
        finish_idle("sub_9_3");

        launch(4'd3, 4'd9, 1'b0);
        wait_result("sub_3_9", 1'b0, 1'b0);
        finish_idle("sub_3_9");

        launch(4'd0, 4'd0, 1'b1);
        wait_result("wrap_0_0_1", 1'b0, 1'b0);
        finish_idle("wrap_0_0_1");

        // Start held high through DONE: the next op begins with no IDLE gap.
        launch(4'hF, 4'hF, 1'b0);
        wait_result("b2b_first", 1'b1, 1'b0);
        launch(4'd7, 4'd2, 1'b1);
        wait_result("b2b_second", 1'b0, 1'b0);
        finish_idle("b2b_second");

        // Operand changes and a start pulse during SHIFT are ignored.
        launch(4'd12, 4'd5, 1'b0);
        wait_result("ignore_start", 1'b0, 1'b1);
        finish_idle("ignore_start");

        // Asynchronous reset in the second SHIFT cycle.
        a     = 4'd6;
        b     = 4'd1;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_busy_before", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_d", 32'(d), 0);
        check("abort_bout", 32'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
        check("abort_ovf", 32'(ovf), 0);
`endif
        @(negedge clk);
        rst       = 1'b0;
        held_d    = '0;
        held_bout = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("abort_no_done", 32'(done_seen), 0);
        check("abort_idle", 32'(busy), 0);

        // Signed overflow cases (d/bout checked in every build).
        launch(4'd8, 4'd1, 1'b0);
        wait_result("ovf_8_1", 1'b0, 1'b0);
        finish_idle("ovf_8_1");
        launch(4'd5, 4'd2, 1'b0);
        wait_result("ovf_5_2", 1'b0, 1'b0);
        finish_idle("ovf_5_2");

        for (int k = 0; k < 6; k++) begin
            launch(W'($urandom), W'($urandom), 1'($urandom));
            wait_result("random", 1'b0, 1'b0);
            finish_idle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
